// File: rtl/mux_select_arbiter_pkg.sv
// Shared encodings for the datapath mux arbiters: FSM state codes and source IDs.
package mux_select_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_ONE = 2'd1,
        ST_GNT_TWO = 2'd2
    } arb_state_t;

    localparam logic SRC_ONE = 1'b0;
    localparam logic SRC_TWO = 1'b1;

endpackage

// File: rtl/mux_select_arbiter_hold_counter.sv
// Grant hold counter: counts cycles of the current grant and flags when the
// preemption threshold (HOLD_MAX-1) is reached.
module mux_select_arbiter_hold_counter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_saturate,
    output logic o_limit
);

    // With preemption disabled the counter simply parks at its maximum value.
    localparam logic [CNT_W-1:0] LIMIT = (HOLD_MAX == 0) ? {CNT_W{1'b1}}
                                                         : CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !(i_saturate && (r_cnt == LIMIT))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_limit = (HOLD_MAX != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/mux_select_arbiter.sv
// Two-source round-robin arbiter driving the select line of the shared 2:1 mux
// bank, with hold-limit preemption under contention.
module mux_select_arbiter
    import mux_select_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_req_one,
    input  logic in_req_two,
    output logic ou_grant_one,
    output logic ou_grant_two,
    output logic ou_select,
    output logic ou_busy,
    output logic ou_timeout
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_last_served;
    logic       r_grant_one;
    logic       r_grant_two;
    logic       r_select;
    logic       r_busy;
    logic       r_timeout;
    logic       w_req_one;
    logic       w_req_two;
    logic       w_preempt;
    logic       w_contend;
    logic       w_limit;

    // An if-condition treats X/Z as false, so unknown requests read as idle.
    always_comb begin
        w_req_one = 1'b0;
        w_req_two = 1'b0;
        if (in_req_one) w_req_one = 1'b1;
        if (in_req_two) w_req_two = 1'b1;
    end

    assign w_contend = ((r_state == ST_GNT_ONE) && w_req_two) ||
                       ((r_state == ST_GNT_TWO) && w_req_one);

    always_comb begin
        w_next    = r_state;
        w_preempt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_one && w_req_two) begin
                    w_next = (r_last_served == SRC_ONE) ? ST_GNT_TWO : ST_GNT_ONE;
                end else if (w_req_one) begin
                    w_next = ST_GNT_ONE;
                end else if (w_req_two) begin
                    w_next = ST_GNT_TWO;
                end
            end
            ST_GNT_ONE: begin
                if (!w_req_one) begin
                    w_next = w_req_two ? ST_GNT_TWO : ST_IDLE;
                end else if (w_limit && w_req_two) begin
                    w_next    = ST_GNT_TWO;
                    w_preempt = 1'b1;
                end
            end
            ST_GNT_TWO: begin
                if (!w_req_two) begin
                    w_next = w_req_one ? ST_GNT_ONE : ST_IDLE;
                end else if (w_limit && w_req_one) begin
                    w_next    = ST_GNT_ONE;
                    w_preempt = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Counter restarts on every change of owner, including direct handover.
    mux_select_arbiter_hold_counter #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (CNT_W)
    ) u_hold_counter (
        .i_clk      (in_clk),
        .i_rst      (in_rst),
        .i_clear    (w_next != r_state),
        .i_enable   (r_state != ST_IDLE),
        .i_saturate (!w_contend),
        .o_limit    (w_limit)
    );

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state       <= ST_IDLE;
            r_last_served <= SRC_TWO;
            r_grant_one   <= 1'b0;
            r_grant_two   <= 1'b0;
            r_select      <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_grant_one <= (w_next == ST_GNT_ONE);
            r_grant_two <= (w_next == ST_GNT_TWO);
            r_busy      <= (w_next != ST_IDLE);
            r_timeout   <= w_preempt;
            if (w_next == ST_GNT_ONE) begin
                r_select <= 1'b0;
                if (r_state != ST_GNT_ONE) r_last_served <= SRC_ONE;
            end else if (w_next == ST_GNT_TWO) begin
                r_select <= 1'b1;
                if (r_state != ST_GNT_TWO) r_last_served <= SRC_TWO;
            end
        end
    end

    assign ou_grant_one = r_grant_one;
    assign ou_grant_two = r_grant_two;
    assign ou_select    = r_select;
    assign ou_busy      = r_busy;
    assign ou_timeout   = r_timeout;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed bench for mux_select_arbiter; outputs viewed as {grant_one, grant_two, select, busy, timeout}.
module tb_mux_select_arbiter;

    logic in_clk = 1'b0;
    logic in_rst = 1'b1;
    logic in_req_one = 1'b0;
    logic in_req_two = 1'b0;
    logic ou_grant_one, ou_grant_two, ou_select, ou_busy, ou_timeout;
    logic [4:0] w_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 in_clk = ~in_clk;

    mux_select_arbiter #(
        .HOLD_MAX (8),
        .CNT_W    (4)
    ) dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_req_one   (in_req_one),
        .in_req_two   (in_req_two),
        .ou_grant_one (ou_grant_one),
        .ou_grant_two (ou_grant_two),
        .ou_select    (ou_select),
        .ou_busy      (ou_busy),
        .ou_timeout   (ou_timeout)
    );

    assign w_out = {ou_grant_one, ou_grant_two, ou_select, ou_busy, ou_timeout};

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic test_reset();
        in_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_req_one = 1'($urandom_range(0, 1));
            in_req_two = 1'($urandom_range(0, 1));
            step();
            n_checks++;
            if (w_out !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got %b want %b", i, w_out, 5'b00000);
            end
        end
        in_rst = 1'b0;
        in_req_one = 1'b1;
        in_req_two = 1'b1;
        step();
        n_checks++;
        if (w_out !== 5'b10010) begin
            n_fail++;
            $display("FAIL reset_first_tie: got %b want %b", w_out, 5'b10010);
        end
        in_req_one = 1'b0;
        in_req_two = 1'b0;
        step();
        n_checks++;
        if (w_out !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", w_out, 5'b00000);
        end
    endtask

    task automatic test_single();
        in_req_two = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (w_out !== 5'b01110) begin
                n_fail++;
                $display("FAIL single_grant[%0d]: got %b want %b", i, w_out, 5'b01110);
            end
        end
        in_req_two = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (w_out !== 5'b00100) begin
                n_fail++;
                $display("FAIL single_idle_select[%0d]: got %b want %b", i, w_out, 5'b00100);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_tab [9];
        logic       r1_tab  [9];
        logic       r2_tab  [9];
        // Requests applied before each edge, and the outputs expected after it.
        r1_tab = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
        r2_tab = '{1, 1, 1, 1, 1, 1, 0, 1, 0};
        exp_tab = '{5'b10010, 5'b10010, 5'b10010, 5'b01110, 5'b01110,
                    5'b01110, 5'b10010, 5'b01110, 5'b00100};
        for (int i = 0; i < 9; i++) begin
            in_req_one = r1_tab[i];
            in_req_two = r2_tab[i];
            step();
            n_checks++;
            if (w_out !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: got %b want %b", i, w_out, exp_tab[i]);
            end
        end
    endtask

    task automatic test_preempt();
        in_req_one = 1'b1;
        in_req_two = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 2) in_req_two = 1'b1;
            n_checks++;
            if (w_out !== 5'b10010) begin
                n_fail++;
                $display("FAIL preempt_hold[%0d]: got %b want %b", k, w_out, 5'b10010);
            end
        end
        step();
        n_checks++;
        if (w_out !== 5'b01111) begin
            n_fail++;
            $display("FAIL preempt_switch: got %b want %b", w_out, 5'b01111);
        end
        step();
        n_checks++;
        if (w_out !== 5'b01110) begin
            n_fail++;
            $display("FAIL preempt_pulse_end: got %b want %b", w_out, 5'b01110);
        end
        in_req_one = 1'b0;
        in_req_two = 1'b0;
        step();
        n_checks++;
        if (w_out !== 5'b00100) begin
            n_fail++;
            $display("FAIL preempt_idle: got %b want %b", w_out, 5'b00100);
        end
        in_req_one = 1'b1;
        in_req_two = 1'b1;
        step();
        n_checks++;
        if (w_out !== 5'b10010) begin
            n_fail++;
            $display("FAIL preempt_last_served: got %b want %b", w_out, 5'b10010);
        end
    endtask

    task automatic test_no_contention();
        in_req_one = 1'b1;
        in_req_two = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (w_out !== 5'b10010) begin
                n_fail++;
                $display("FAIL no_contention[%0d]: got %b want %b", i, w_out, 5'b10010);
            end
        end
        in_req_one = 1'b0;
        step();
        n_checks++;
        if (w_out !== 5'b00000) begin
            n_fail++;
            $display("FAIL no_contention_release: got %b want %b", w_out, 5'b00000);
        end
    endtask

    task automatic test_x_and_reset();
        in_req_one = 1'b0;
        in_req_two = 1'bx;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (w_out !== 5'b00000) begin
                n_fail++;
                $display("FAIL x_request_idle[%0d]: got %b want %b", i, w_out, 5'b00000);
            end
        end
        in_req_two = 1'b0;
        in_req_one = 1'b1;
        step();
        n_checks++;
        if (w_out !== 5'b10010) begin
            n_fail++;
            $display("FAIL pre_reset_grant: got %b want %b", w_out, 5'b10010);
        end
        in_rst = 1'b1;
        step();
        n_checks++;
        if (w_out !== 5'b00000) begin
            n_fail++;
            $display("FAIL mid_grant_reset: got %b want %b", w_out, 5'b00000);
        end
        in_rst = 1'b0;
        in_req_one = 1'b0;
        step();
        n_checks++;
        if (w_out !== 5'b00000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b want %b", w_out, 5'b00000);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_preempt();
        test_no_contention();
        test_x_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
